// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// ALU/source select codes and error codes.
package mcu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12,
      S_ERROR  = 4'd15
   } state_t;

   localparam logic [1:0] ALU_FUNCT = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_ADD   = 2'b11;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // States that wait on the memory-ready handshake and run the stall counter.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mcu_output_decode.sv
// Combinational state -> datapath control decode for the multicycle control unit.
module mcu_output_decode
   import mcu_pkg::*;
(
   input  state_t     i_state,
   input  logic       i_mem_ready,
   input  logic       i_zero,
   output logic       o_pc_write,
   output logic       o_pc_write_cond,
   output logic       o_i_or_d,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_ir_write,
   output logic       o_mem_to_reg,
   output logic       o_reg_dst,
   output logic       o_reg_write,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic [1:0] o_alu_op,
   output logic [1:0] o_pc_src,
   output logic       o_pc_en,
   output logic       o_halted
);

   always_comb begin
      o_pc_write      = 1'b0;
      o_pc_write_cond = 1'b0;
      o_i_or_d        = 1'b0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      o_ir_write      = 1'b0;
      o_mem_to_reg    = 1'b0;
      o_reg_dst       = 1'b0;
      o_reg_write     = 1'b0;
      o_alu_src_a     = 1'b0;
      o_alu_src_b     = SRCB_REGB;
      o_alu_op        = ALU_FUNCT;
      o_pc_src        = PC_ALU;
      case (i_state)
         // PC+4 and the IR load only commit once the fetch completes.
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = SRCB_FOUR;
            o_alu_op    = ALU_ADD;
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            o_alu_src_b = SRCB_IMMSH;
            o_alu_op    = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            o_alu_src_a = 1'b1;
            o_alu_src_b = SRCB_IMM;
            o_alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            o_mem_read = 1'b1;
            o_i_or_d   = 1'b1;
         end
         S_MEMWR: begin
            o_mem_write = 1'b1;
            o_i_or_d    = 1'b1;
         end
         S_MEMWB: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
         end
         S_ADDIWB: o_reg_write = 1'b1;
         S_EXEC: begin
            o_alu_src_a = 1'b1;
            o_alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            o_reg_dst   = 1'b1;
            o_reg_write = 1'b1;
         end
         S_BRANCH: begin
            o_alu_src_a     = 1'b1;
            o_alu_op        = ALU_SUB;
            o_pc_write_cond = 1'b1;
            o_pc_src        = PC_ALUOUT;
         end
         S_JUMP: begin
            o_pc_write = 1'b1;
            o_pc_src   = PC_JUMP;
         end
         default: ;
      endcase
   end

   assign o_pc_en  = o_pc_write | (o_pc_write_cond & i_zero);
   assign o_halted = (i_state == S_ERROR);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory-stall timeout, error halt and retired counter.
// Define MCU_JUMP_EN to decode opcode 000010 as J; otherwise it is an illegal opcode.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int TIMEOUT_W = 4,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic             pc_en,
   output logic             halted,
   output logic [1:0]       err_code,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [TIMEOUT_W-1:0] STALL_LIMIT = '1;

   state_t                 r_state;
   state_t                 w_next;
   logic [TIMEOUT_W-1:0]   r_stall;
   logic [1:0]             r_err;
   logic [CNT_W-1:0]       r_retired;
   logic                   w_retire;
   logic                   w_stalling;
   logic                   w_timeout;
   logic                   w_err_load;
   logic [1:0]             w_err_val;

   // A ready cycle never stalls, so mem_ready=1 always beats the timeout.
   assign w_stalling = is_mem_state(r_state) && !mem_ready;
   assign w_timeout  = w_stalling && (r_stall == STALL_LIMIT);

   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      w_err_load = 1'b0;
      w_err_val  = ERR_NONE;
      if (w_timeout) begin
         w_next     = S_ERROR;
         w_err_load = 1'b1;
         w_err_val  = ERR_TIMEOUT;
      end else begin
         case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_RTYPE:     w_next = S_EXEC;
                  OP_LW, OP_SW: w_next = S_MEMADR;
                  OP_BEQ:       w_next = S_BRANCH;
                  OP_ADDI:      w_next = S_ADDIEX;
`ifdef MCU_JUMP_EN
                  OP_J:         w_next = S_JUMP;
`else
                  OP_J: begin
                     w_next     = S_ERROR;
                     w_err_load = 1'b1;
                     w_err_val  = ERR_ILLEGAL;
                  end
`endif
                  default: begin
                     w_next     = S_ERROR;
                     w_err_load = 1'b1;
                     w_err_val  = ERR_ILLEGAL;
                  end
               endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_retire = 1'b1;
            S_EXEC:   w_next = S_RWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_IDLE;
         endcase
         if (w_retire) w_next = run ? S_FETCH : S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_stall   <= '0;
         r_err     <= ERR_NONE;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         r_stall <= w_stalling ? r_stall + TIMEOUT_W'(1) : '0;
         if (w_err_load) r_err <= w_err_val;
         if (w_retire) r_retired <= r_retired + CNT_W'(1);
      end
   end

   mcu_output_decode u_decode (
      .i_state        (r_state),
      .i_mem_ready    (mem_ready),
      .i_zero         (zero),
      .o_pc_write     (pc_write),
      .o_pc_write_cond(pc_write_cond),
      .o_i_or_d       (i_or_d),
      .o_mem_read     (mem_read),
      .o_mem_write    (mem_write),
      .o_ir_write     (ir_write),
      .o_mem_to_reg   (mem_to_reg),
      .o_reg_dst      (reg_dst),
      .o_reg_write    (reg_write),
      .o_alu_src_a    (alu_src_a),
      .o_alu_src_b    (alu_src_b),
      .o_alu_op       (alu_op),
      .o_pc_src       (pc_src),
      .o_pc_en        (pc_en),
      .o_halted       (halted)
   );

   assign state    = r_state;
   assign err_code = r_err;
   assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard testbench for multicycle_control_unit: per-cycle expected state and
// controls are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control_unit;

   localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWR = 4'd6,
      ST_EXEC = 4'd7, ST_RWB = 4'd8, ST_BRANCH = 4'd9, ST_ADDIEX = 4'd10,
      ST_ADDIWB = 4'd11, ST_JUMP = 4'd12, ST_ERROR = 4'd15;
   localparam int TIMEOUT_CYCLES = 16;

   logic        clk = 1'b0;
   logic        rst_n, run, zero, mem_ready;
   logic [5:0]  opcode;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, pc_en, halted;
   logic [1:0]  alu_src_b, alu_op, pc_src, err_code;
   logic [3:0]  state;
   logic [31:0] retired;
   logic [17:0] ctlVec;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [17:0] ctl;
      logic [31:0] ret;
      logic [1:0]  err;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cycleNo = 0;
   logic [31:0] expRetired = 0;
   logic [1:0]  expErr = 0;

   multicycle_control_unit #(.TIMEOUT_W(4), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en), .halted(halted),
      .err_code(err_code), .state(state), .retired(retired)
   );

   always #5 clk = ~clk;

   assign ctlVec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_src, pc_en, halted};

   // Expected controls for a state, taken straight from the per-state output table.
   function automatic logic [17:0] expCtl(input logic [3:0] st, input logic mr, input logic z);
      logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         4'd1:        begin mrd = 1; asb = 2'b01; aop = 2'b11; irw = mr; pw = mr; end
         4'd2:        begin asb = 2'b11; aop = 2'b11; end
         4'd3, 4'd10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
         4'd4:        begin mrd = 1; iod = 1; end
         4'd6:        begin mwr = 1; iod = 1; end
         4'd5:        begin rw = 1; m2r = 1; end
         4'd11:       rw = 1;
         4'd7:        asa = 1;
         4'd8:        begin rdst = 1; rw = 1; end
         4'd9:        begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
         4'd12:       begin pw = 1; psrc = 2'b10; end
         default:     ;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc,
              pw | (pwc & z), st == 4'd15};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         checkOutput({e.tag, "_state"}, {28'd0, state}, {28'd0, e.st});
         checkOutput({e.tag, "_ctl"}, {14'd0, ctlVec}, {14'd0, e.ctl});
         checkOutput({e.tag, "_retired"}, retired, e.ret);
         checkOutput({e.tag, "_err"}, {30'd0, err_code}, {30'd0, e.err});
      end
   end

   // Describe one clock cycle: inputs held during it and the state it should show.
   task automatic driveCycle(input logic [3:0] st, input logic mr, input logic z, input string tag);
      exp_t e;
      mem_ready = mr;
      zero      = z;
      e.tag = $sformatf("%s@%0d", tag, cycleNo);
      e.st  = st;
      e.ctl = expCtl(st, mr, z);
      e.ret = expRetired;
      e.err = expErr;
      sbq.push_back(e);
      cycleNo++;
      @(posedge clk);
      #1;
   endtask

   task automatic memPhase(input logic [3:0] st, input int waits, input logic isLast,
                           input logic runFinal, input logic z, output logic timedOut);
      for (int i = 0; i < waits && i < TIMEOUT_CYCLES; i++) driveCycle(st, 1'b0, z, "stall");
      if (waits >= TIMEOUT_CYCLES) begin
         timedOut = 1'b1;
      end else begin
         if (isLast) run = runFinal;
         driveCycle(st, 1'b1, z, "ready");
         timedOut = 1'b0;
      end
   endtask

   task automatic errorTail(input logic [1:0] code);
      expErr = code;
      run    = 1'b1;
      driveCycle(ST_ERROR, 1'b1, 1'b0, "error");
      driveCycle(ST_ERROR, 1'b1, 1'b0, "errorHold");
   endtask

   task automatic lastState(input logic [3:0] st, input logic z, input logic runAfter);
      run = runAfter;
      driveCycle(st, 1'b0, z, "last");
      expRetired++;
   endtask

   task automatic applyStimulus(input logic [5:0] op, input int fetchWaits, input int memWaits,
                                input logic z, input logic fromIdle, input logic runAfter);
      logic to;
      run    = 1'b1;
      opcode = op;
      if (fromIdle) driveCycle(ST_IDLE, 1'b0, z, "idleGo");
      memPhase(ST_FETCH, fetchWaits, 1'b0, 1'b1, z, to);
      if (to) begin errorTail(2'b10); return; end
      driveCycle(ST_DECODE, 1'b0, z, "decode");
      case (op)
         6'b000000: begin
            driveCycle(ST_EXEC, 1'b0, z, "exec");
            lastState(ST_RWB, z, runAfter);
         end
         6'b100011: begin
            driveCycle(ST_MEMADR, 1'b0, z, "memadr");
            memPhase(ST_MEMRD, memWaits, 1'b0, 1'b1, z, to);
            if (to) begin errorTail(2'b10); return; end
            lastState(ST_MEMWB, z, runAfter);
         end
         6'b101011: begin
            driveCycle(ST_MEMADR, 1'b0, z, "memadr");
            memPhase(ST_MEMWR, memWaits, 1'b1, runAfter, z, to);
            if (to) begin errorTail(2'b10); return; end
            expRetired++;
         end
         6'b000100: lastState(ST_BRANCH, z, runAfter);
         6'b001000: begin
            driveCycle(ST_ADDIEX, 1'b0, z, "addiex");
            lastState(ST_ADDIWB, z, runAfter);
         end
`ifdef MCU_JUMP_EN
         6'b000010: lastState(ST_JUMP, z, runAfter);
`endif
         default: errorTail(2'b01);
      endcase
   endtask

   task automatic doReset();
      run   = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("rstState", {28'd0, state}, 32'd0);
      checkOutput("rstRetired", retired, 32'd0);
      checkOutput("rstErr", {30'd0, err_code}, 32'd0);
      checkOutput("rstCtl", {14'd0, ctlVec}, 32'd0);
      expRetired = 0;
      expErr     = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      doReset();
      driveCycle(ST_IDLE, 1'b0, 1'b0, "idleHold");

      applyStimulus(6'b000000, 0, 0, 1'b0, 1'b1, 1'b1);
      applyStimulus(6'b100011, 0, 3, 1'b0, 1'b0, 1'b1);
      applyStimulus(6'b101011, 0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(6'b001000, 0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(6'b000100, 0, 0, 1'b1, 1'b0, 1'b1);
      applyStimulus(6'b000100, 0, 0, 1'b0, 1'b0, 1'b0);
      run = 1'b0;
      driveCycle(ST_IDLE, 1'b1, 1'b0, "idleAfterRun0");

      applyStimulus(6'b000000, 15, 0, 1'b0, 1'b1, 1'b1);
      applyStimulus(6'b000000, 16, 0, 1'b0, 1'b0, 1'b1);
      doReset();

      applyStimulus(6'b000000, 0, 0, 1'b0, 1'b1, 1'b1);
      opcode = 6'b100011;
      driveCycle(ST_FETCH, 1'b1, 1'b0, "midFetch");
      driveCycle(ST_DECODE, 1'b0, 1'b0, "midDecode");
      doReset();

      applyStimulus(6'b111111, 0, 0, 1'b0, 1'b1, 1'b1);
      doReset();
      applyStimulus(6'b000010, 0, 0, 1'b0, 1'b1, 1'b0);
      doReset();
      applyStimulus(6'b101011, 2, 16, 1'b0, 1'b1, 1'b1);
      doReset();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
